// File: rtl/sliding_window_gen_if.sv
// sliding_window_gen_if
// Stream bundle for sliding_window_gen: one raster-order pixel input stream
// and one window output stream, both valid/ready handshaked.
//   inValid/inReady/inPixel  : pixel stream into the window generator
//   inSof                    : start-of-frame resync (only with SWG_SOF_RESYNC_EN)
//   outValid/outReady        : window stream handshake
//   window                   : WIN x WIN taps, tap (r,c) at [(r*WIN+c)*PIX_W +: PIX_W]
//   outX/outY                : image coordinates of the window centre
//   outLast                  : last window of the frame
//   frameDone                : one-cycle pulse when the final frame pixel is taken
// Modports: slave = the window generator, master = the stream environment.
// Optional feature macro: SWG_SOF_RESYNC_EN.
interface sliding_window_gen_if #(
    parameter int PIX_W = 4,
    parameter int WIN   = 3,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
) ();
    logic                     inValid;
    logic                     inReady;
    logic [PIX_W-1:0]         inPixel;
`ifdef SWG_SOF_RESYNC_EN
    logic                     inSof;
`endif
    logic                     outValid;
    logic                     outReady;
    logic [WIN*WIN*PIX_W-1:0] window;
    logic [X_W-1:0]           outX;
    logic [Y_W-1:0]           outY;
    logic                     outLast;
    logic                     frameDone;

    modport slave (
`ifdef SWG_SOF_RESYNC_EN
        input  inSof,
`endif
        input  inValid,
        input  inPixel,
        input  outReady,
        output inReady,
        output outValid,
        output window,
        output outX,
        output outY,
        output outLast,
        output frameDone
    );

    modport master (
`ifdef SWG_SOF_RESYNC_EN
        output inSof,
`endif
        output inValid,
        output inPixel,
        output outReady,
        input  inReady,
        input  outValid,
        input  window,
        input  outX,
        input  outY,
        input  outLast,
        input  frameDone
    );
endinterface

// File: rtl/sliding_window_gen.sv
// sliding_window_gen
// Builds WIN x WIN pixel windows from a raster-order pixel stream using WIN-1
// line buffers and a register window, and emits each fully populated window
// with the coordinates of its centre pixel. Valid/ready on both sides; a
// pending window stalls the input.
// Ports:
//   mainClk : single clock
//   reset   : synchronous active-high reset
//   bus     : sliding_window_gen_if.slave (pixel in, window out, frame flags)
// Optional feature macro: SWG_SOF_RESYNC_EN adds bus.inSof, which forces the
// accepted pixel to position (0,0).
module sliding_window_gen #(
    parameter int PIX_W     = 4,
    parameter int WIN       = 3,
    parameter int LINE_W    = 640,
    parameter int NUM_LINES = 480,
    parameter int X_W       = 10,
    parameter int Y_W       = 9
) (
    input  logic                 mainClk,
    input  logic                 reset,
    sliding_window_gen_if.slave  bus
);

    localparam int HALF = WIN / 2;
    localparam logic [X_W-1:0] X_LAST = X_W'(LINE_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(NUM_LINES - 1);
    localparam logic [X_W-1:0] X_FULL = X_W'(WIN - 1);
    localparam logic [Y_W-1:0] Y_FULL = Y_W'(WIN - 1);
    localparam logic [X_W-1:0] X_HALF = X_W'(HALF);
    localparam logic [Y_W-1:0] Y_HALF = Y_W'(HALF);

    // raster position of the next input pixel
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    // r_lineBuf[0] holds the oldest stored line
    logic [PIX_W-1:0] r_lineBuf [WIN-1][LINE_W];
    logic [PIX_W-1:0] r_win     [WIN][WIN];

    logic             r_outValid;
    logic [X_W-1:0]   r_outX;
    logic [Y_W-1:0]   r_outY;
    logic             r_outLast;
    logic             r_frameDone;

    logic [PIX_W-1:0]         w_col [WIN];
    logic [WIN*WIN*PIX_W-1:0] w_window;
    logic                     w_acc;
    logic                     w_sof;
    logic                     w_emit;
    logic                     w_lastPos;
    logic [X_W-1:0]           w_x;
    logic [Y_W-1:0]           w_y;

    assign bus.inReady = ~r_outValid | bus.outReady;
    assign w_acc       = bus.inValid & bus.inReady;

`ifdef SWG_SOF_RESYNC_EN
    assign w_sof = bus.inSof;
`else
    assign w_sof = 1'b0;
`endif

    // A resync pixel is placed at (0,0) before column formation.
    assign w_x = w_sof ? {X_W{1'b0}} : r_x;
    assign w_y = w_sof ? {Y_W{1'b0}} : r_y;

    assign w_lastPos = (w_x == X_LAST) && (w_y == Y_LAST);
    // Only windows that lie entirely inside the current frame lines are emitted,
    // so stale line-buffer and window contents never reach the output.
    assign w_emit = w_acc && !w_sof && (w_x >= X_FULL) && (w_y >= Y_FULL);

    // New column: stored lines at the current x (pre-write values) plus the input pixel.
    always_comb begin
        for (int r = 0; r < WIN - 1; r++) begin
            w_col[r] = r_lineBuf[r][w_x];
        end
        w_col[WIN-1] = bus.inPixel;
    end

    // Pack the register window onto the output bus.
    always_comb begin
        w_window = {(WIN*WIN*PIX_W){1'b0}};
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                w_window[(r*WIN+c)*PIX_W +: PIX_W] = r_win[r][c];
            end
        end
    end

    assign bus.window    = w_window;
    assign bus.outValid  = r_outValid;
    assign bus.outX      = r_outX;
    assign bus.outY      = r_outY;
    assign bus.outLast   = r_outLast;
    assign bus.frameDone = r_frameDone;

    // Line buffers shift up by one line at the current column; never cleared.
    always_ff @(posedge mainClk) begin
        if (!reset && w_acc) begin
            for (int r = 0; r < WIN - 1; r++) begin
                r_lineBuf[r][w_x] <= w_col[r+1];
            end
        end
    end

    // Register window: shift every row left and insert the new column on the right.
    always_ff @(posedge mainClk) begin
        if (reset) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    r_win[r][c] <= {PIX_W{1'b0}};
                end
            end
        end else if (w_acc) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][WIN-1] <= w_col[r];
            end
        end
    end

    // Raster counters with line and frame wrap.
    always_ff @(posedge mainClk) begin
        if (reset) begin
            r_x <= {X_W{1'b0}};
            r_y <= {Y_W{1'b0}};
        end else if (w_acc) begin
            if (w_x == X_LAST) begin
                r_x <= {X_W{1'b0}};
                r_y <= (w_y == Y_LAST) ? {Y_W{1'b0}} : (w_y + Y_W'(1));
            end else begin
                r_x <= w_x + X_W'(1);
                r_y <= w_y;
            end
        end
    end

    // Output window handshake, centre coordinates and frame flags.
    always_ff @(posedge mainClk) begin
        if (reset) begin
            r_outValid  <= 1'b0;
            r_outX      <= {X_W{1'b0}};
            r_outY      <= {Y_W{1'b0}};
            r_outLast   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_acc && !w_sof && w_lastPos;
            if (w_acc) begin
                r_outValid <= w_emit;
                if (w_emit) begin
                    r_outX    <= w_x - X_HALF;
                    r_outY    <= w_y - Y_HALF;
                    r_outLast <= w_lastPos;
                end
            end else if (bus.outReady) begin
                r_outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// tb_sliding_window_gen
// Self-checking bench for sliding_window_gen with WIN=3, LINE_W=8, NUM_LINES=6.
// A position-indexed image model predicts every window, its centre, outLast
// and frameDone; directed phases cover ramp, backpressure, frame wrap, idle
// gaps, mid-frame reset and (with SWG_SOF_RESYNC_EN) start-of-frame resync.
module tb_sliding_window_gen;

    localparam int PIX_W     = 4;
    localparam int WIN       = 3;
    localparam int LINE_W    = 8;
    localparam int NUM_LINES = 6;
    localparam int X_W       = 3;
    localparam int Y_W       = 3;
    localparam int HALF      = WIN / 2;
    localparam int WW        = WIN * WIN * PIX_W;
    localparam int TOTAL     = LINE_W * NUM_LINES;

    logic mainClk = 1'b0;
    logic reset   = 1'b1;
    always #5 mainClk = ~mainClk;

    sliding_window_gen_if #(.PIX_W(PIX_W), .WIN(WIN), .X_W(X_W), .Y_W(Y_W)) bus ();

    sliding_window_gen #(
        .PIX_W(PIX_W), .WIN(WIN), .LINE_W(LINE_W), .NUM_LINES(NUM_LINES),
        .X_W(X_W), .Y_W(Y_W)
    ) dut (
        .mainClk (mainClk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [WW-1:0] win;
        int            x;
        int            y;
        bit            last;
    } exp_t;

    exp_t             q[$];
    exp_t             e;
    logic [PIX_W-1:0] img [NUM_LINES][LINE_W];
    int               n_pos    = 0;
    bit               exp_fd   = 1'b0;
    int               xfer_cnt = 0;
    int               fd_cnt   = 0;
    int               pos, px, py;
    logic             sof_w;

`ifdef SWG_SOF_RESYNC_EN
    assign sof_w = bus.inSof;
`else
    assign sof_w = 1'b0;
`endif

    // window of a ramp image (pixel = raster index & 0xF) centred at (cx,cy)
    function automatic logic [WW-1:0] ramp_win(input int cx, input int cy);
        logic [WW-1:0] w;
        int v;
        w = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                v = ((cy - HALF + r) * LINE_W + (cx - HALF + c)) & 15;
                w[(r*WIN+c)*PIX_W +: PIX_W] = PIX_W'(v);
            end
        end
        return w;
    endfunction

    // monitor + scoreboard, sampled on the falling edge
    always @(negedge mainClk) begin
        if (reset) begin
            q.delete();
            n_pos  = 0;
            exp_fd = 1'b0;
        end else begin
            chk("outValid", 64'(bus.outValid), 64'(q.size() != 0));
            chk("frameDone", 64'(bus.frameDone), 64'(exp_fd));
            if (bus.frameDone) fd_cnt++;
            if (bus.outValid && bus.outReady) begin
                xfer_cnt++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("window", 64'(bus.window), 64'(e.win));
                    chk("outX", 64'(bus.outX), 64'(e.x));
                    chk("outY", 64'(bus.outY), 64'(e.y));
                    chk("outLast", 64'(bus.outLast), 64'(e.last));
                end
            end
            exp_fd = 1'b0;
            if (bus.inValid && bus.inReady) begin
                pos = sof_w ? 0 : n_pos;
                px  = pos % LINE_W;
                py  = pos / LINE_W;
                img[py][px] = bus.inPixel;
                if (!sof_w && px >= WIN - 1 && py >= WIN - 1) begin
                    e.win = '0;
                    for (int r = 0; r < WIN; r++) begin
                        for (int c = 0; c < WIN; c++) begin
                            e.win[(r*WIN+c)*PIX_W +: PIX_W] = img[py-2*HALF+r][px-2*HALF+c];
                        end
                    end
                    e.x    = px - HALF;
                    e.y    = py - HALF;
                    e.last = (pos == TOTAL - 1);
                    q.push_back(e);
                end
                exp_fd = !sof_w && (pos == TOTAL - 1);
                n_pos  = (pos + 1) % TOTAL;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rdy_random = 1'b0;
    bit rdy_force  = 1'b1;

    // downstream ready: forced level or random
    always @(posedge mainClk) begin
        #2;
        bus.outReady = rdy_random ? ($urandom_range(0, 2) != 0) : rdy_force;
    end

    task automatic push_pix(input logic [PIX_W-1:0] p);
        bit got;
        int t;
        got = 1'b0;
        t   = 0;
        bus.inValid = 1'b1;
        bus.inPixel = p;
        while (!got && t < 200) begin
            @(negedge mainClk);
            got = bus.inValid && bus.inReady;
            @(posedge mainClk);
            #1;
            t++;
        end
        bus.inValid = 1'b0;
        chk("accepted", 64'(got), 64'd1);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge mainClk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outValid"}, 64'(bus.outValid), 64'd0);
        chk({tag, "_outX"}, 64'(bus.outX), 64'd0);
        chk({tag, "_outY"}, 64'(bus.outY), 64'd0);
        chk({tag, "_outLast"}, 64'(bus.outLast), 64'd0);
        chk({tag, "_frameDone"}, 64'(bus.frameDone), 64'd0);
        chk({tag, "_window"}, 64'(bus.window), 64'd0);
    endtask

    int base_x;
    int fd_base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inValid = 1'b0;
        bus.inPixel = '0;
`ifdef SWG_SOF_RESYNC_EN
        bus.inSof = 1'b0;
`endif
        repeat (3) @(posedge mainClk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        #1;
        chk("reset_inReady", 64'(bus.inReady), 64'd1);

        // ramp, two frames back to back, outReady held high
        base_x = xfer_cnt;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < TOTAL; i++) begin
                push_pix(PIX_W'(i & 15));
                if (f == 1 && i == 0)
                    chk("frame0_windows", 64'(xfer_cnt - base_x), 64'd24);
                if (i == 17) chk("ramp_pre_valid", 64'(bus.outValid), 64'd0);
                if (i == 18) begin
                    chk("ramp_first_valid", 64'(bus.outValid), 64'd1);
                    chk("ramp_first_x", 64'(bus.outX), 64'd1);
                    chk("ramp_first_y", 64'(bus.outY), 64'd1);
                    chk("ramp_first_win", 64'(bus.window), 64'(ramp_win(1, 1)));
                end
                if (i == TOTAL - 1) begin
                    chk("last_x", 64'(bus.outX), 64'd6);
                    chk("last_y", 64'(bus.outY), 64'd4);
                    chk("last_flag", 64'(bus.outLast), 64'd1);
                    chk("last_frameDone", 64'(bus.frameDone), 64'd1);
                end
            end
        end
        idle(2);
        chk("two_frame_windows", 64'(xfer_cnt - base_x), 64'd48);
        chk("two_frame_done", 64'(fd_cnt), 64'd2);

        // backpressure: stall a pending window for 5 cycles
        for (int i = 0; i <= 20; i++) push_pix(PIX_W'(i & 15));
        rdy_force = 1'b0;
        bus.inValid = 1'b1;
        bus.inPixel = PIX_W'(21);
        repeat (5) begin
            @(negedge mainClk);
            chk("bp_inReady", 64'(bus.inReady), 64'd0);
            chk("bp_valid", 64'(bus.outValid), 64'd1);
            chk("bp_x", 64'(bus.outX), 64'd3);
            chk("bp_y", 64'(bus.outY), 64'd1);
            chk("bp_win", 64'(bus.window), 64'(ramp_win(3, 1)));
        end
        rdy_force = 1'b1;
        @(posedge mainClk);
        #1;
        push_pix(PIX_W'(21));
        rdy_random = 1'b1;
        for (int i = 22; i < TOTAL; i++) push_pix(PIX_W'(i & 15));

        // idle gaps with random downstream ready: ramp frame, then random pixels
        for (int i = 0; i < TOTAL; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            push_pix(PIX_W'(i & 15));
        end
        for (int i = 0; i < TOTAL; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            push_pix(PIX_W'($urandom));
        end
        idle(4);

        // mid-frame reset after pixel 30
        rdy_random = 1'b0;
        rdy_force  = 1'b1;
        idle(1);
        for (int i = 0; i < 30; i++) push_pix(PIX_W'($urandom));
        reset = 1'b1;
        @(posedge mainClk);
        #1;
        check_zero("midreset");
        reset = 1'b0;
        for (int i = 0; i < 19; i++) begin
            push_pix(PIX_W'(i & 15));
            if (i == 17) chk("post_reset_pre_valid", 64'(bus.outValid), 64'd0);
            if (i == 18) begin
                chk("post_reset_valid", 64'(bus.outValid), 64'd1);
                chk("post_reset_x", 64'(bus.outX), 64'd1);
                chk("post_reset_y", 64'(bus.outY), 64'd1);
                chk("post_reset_win", 64'(bus.window), 64'(ramp_win(1, 1)));
            end
        end

`ifdef SWG_SOF_RESYNC_EN
        // start-of-frame resync on the 13th pixel of a fresh stream
        reset = 1'b1;
        @(posedge mainClk);
        #1;
        reset = 1'b0;
        fd_base = fd_cnt;
        for (int i = 0; i < 12; i++) push_pix(PIX_W'($urandom));
        bus.inSof = 1'b1;
        push_pix(PIX_W'(0));
        bus.inSof = 1'b0;
        chk("sof_no_window", 64'(bus.outValid), 64'd0);
        for (int j = 1; j <= 18; j++) begin
            push_pix(PIX_W'(j & 15));
            if (j == 17) chk("sof_pre_valid", 64'(bus.outValid), 64'd0);
            if (j == 18) begin
                chk("sof_valid", 64'(bus.outValid), 64'd1);
                chk("sof_x", 64'(bus.outX), 64'd1);
                chk("sof_y", 64'(bus.outY), 64'd1);
                chk("sof_win", 64'(bus.window), 64'(ramp_win(1, 1)));
            end
        end
        idle(2);
        chk("sof_no_frameDone", 64'(fd_cnt - fd_base), 64'd0);
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sliding_window_gen.md
Name: sliding_window_gen

Overview:
- Parametrised successor of the fixed 3x3, 4-bit pixel window path between the SPI receive logic and edgeDetect.
- Takes a raster-order pixel stream, one pixel per accepted beat, and keeps WIN-1 line buffers plus a WIN x WIN register window.
- Emits each fully populated window together with the image coordinates of its centre pixel.
- Generalises the window size, pixel width and frame geometry, and adds valid/ready backpressure with frame-end signalling.

Parameters:
- PIX_W, 4, bits per pixel
- WIN, 3, window edge length; odd, >=3
- LINE_W, 640, pixels per line
- NUM_LINES, 480, lines per frame
- X_W, 10, x coordinate width; must satisfy 2**X_W >= LINE_W
- Y_W, 9, y coordinate width; must satisfy 2**Y_W >= NUM_LINES

Ports:
- mainClk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- inValid  in  1  inPixel valid
- inReady  out  1  block can accept a pixel this cycle
- inPixel  in  PIX_W  pixel at the current raster position
- outValid  out  1  window valid
- outReady  in  1  downstream accepts the window
- window  out  WIN*WIN*PIX_W  tap (r,c) at bits [(r*WIN+c)*PIX_W +: PIX_W]; r=0 is the oldest line, c=0 is the leftmost column
- outX  out  X_W  centre x coordinate
- outY  out  Y_W  centre y coordinate
- outLast  out  1  this is the last window of the frame
- frameDone  out  1  one-cycle pulse when the frame's final pixel is accepted

Behaviour:
- Accept: acc = inValid & inReady, where inReady = ~outValid | outReady (combinational).
- Internal raster counters x, y track the position of the next input pixel. Both reset to 0.
- On acc, column formation: col[WIN-1] = inPixel; col[r] = lineBuf[r][x] for r < WIN-1. Reads return the pre-write value.
- On acc, line buffer update: lineBuf[r][x] <= col[r+1].
- On acc, window update: every row shifts left by one column, and col enters column WIN-1.
- Emission rule: if x >= WIN-1 and y >= WIN-1 at acceptance, then on the next cycle:
  - outValid = 1
  - outX = x - WIN/2, outY = y - WIN/2
  - outLast = 1 when (x,y) = (LINE_W-1, NUM_LINES-1)
- An acceptance that does not meet the emission rule, with outValid=0 or outReady=1, leaves outValid = 0.
- Hold: while outValid & ~outReady, window, outX, outY and outLast are stable, and inReady = 0.
- Latency is 1 cycle from acceptance to outValid. Sustained throughput is 1 pixel per cycle when outReady is held high.
- Counter wrap, on acc:
  - x = LINE_W-1 sets x <= 0 and y <= y+1.
  - Additionally, y = NUM_LINES-1 sets y <= 0 and pulses frameDone (registered, same cycle as the last outValid).
- Windows never span frames or line edges. Stale columns and lines are present in the registers but are never emitted, because of the emission rule.
- Reset, including mid-frame:
  - All outputs go to 0, x = y = 0, and any pending window is dropped.
  - Line buffer contents are not cleared; they are don't-care because of the emission rule.
  - inReady = 1 in the first cycle after reset.
- Consecutive window columns use an unbroken sequence of accepted pixels. Idle cycles (inValid=0) do not shift the window.

Optional Feature:
- Macro: SWG_SOF_RESYNC_EN.
- When defined: adds input port inSof (1 bit).
  - On acc with inSof=1, the pixel is treated as position (0,0) and x, y are forced to 0 before column formation.
  - That acceptance produces no window. The counters continue from (1,0).
  - frameDone is not pulsed by a resync.
- When undefined: no inSof port; position is derived only from counters and reset.

Test Plan:
- Ramp, WIN=3, LINE_W=8, NUM_LINES=6, inPixel=(y*8+x)&0xF, outReady=1:
  - First outValid occurs 1 cycle after the 19th accepted pixel, with outX=1, outY=1.
  - window rows = {0,1,2},{8,9,10},{0,1,2}.
  - Exactly 24 windows per frame.
- Backpressure: hold outReady=0 for 5 cycles while a window is pending -> inReady=0; window, outX and outY are unchanged. The release cycle completes the transfer, with no loss or duplication.
- Frame wrap: stream two frames back to back -> frameDone and outLast at centre (6,4) after pixel 48; the second frame's first window appears after its 19th pixel with (1,1).
- Idle gaps: insert random inValid=0 cycles -> the window sequence is identical to the gapless run.
- Reset mid-frame: assert reset after pixel 30 -> all outputs are 0 the next cycle. The following stream produces its first window after 19 pixels with (1,1).
- SWG_SOF_RESYNC_EN: assert inSof on pixel 13 -> no window for that beat; the next window appears after 18 more pixels with (1,1), and frameDone does not pulse.
